// File: rtl/temp_reg_pkg.sv
// Shared state encoding, parameter defaults and the saturating gain helper
// for the fan-speed temperature regulator.
package temp_reg_pkg;

    localparam int unsigned GAIN_DEF     = 4;
    localparam int unsigned STEP_DEF     = 8;
    localparam int unsigned RAMP_DIV_DEF = 16;
    localparam int unsigned TIMEOUT_DEF  = 1024;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_COOL  = 2'd1;
    localparam logic [1:0] ST_HEAT  = 2'd2;
    localparam logic [1:0] ST_FAULT = 2'd3;

    // Wide product so any 8-bit error times any gain saturates cleanly to 255.
    function automatic logic [7:0] sat_scale(input logic [7:0] diff, input int unsigned gain);
        logic [39:0] prod;
        prod = 40'(diff) * 40'(gain);
        return (prod > 40'd255) ? 8'hFF : prod[7:0];
    endfunction

endpackage

// File: rtl/ramp_limiter.sv
// Slew limiter: free-running prescaler producing a ramp tick every RAMP_DIV
// clocks, and a speed register that steps toward the target by at most STEP.
module ramp_limiter
    import temp_reg_pkg::*;
#(
    parameter int unsigned STEP     = STEP_DEF,
    parameter int unsigned RAMP_DIV = RAMP_DIV_DEF
) (
    input  logic       i_clk,
    input  logic       i_arst_n,
    input  logic       i_tick_en,
    input  logic [7:0] i_target,
    output logic [7:0] o_speed
);

    localparam int unsigned      PRE_W    = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(RAMP_DIV - 1);
    localparam logic [9:0]       STEP_W   = 10'(STEP);

    logic [PRE_W-1:0] r_pre;
    logic [7:0]       r_speed;
    logic [7:0]       w_speed_d;
    logic             w_tick;
    logic [9:0]       w_up;
    logic [7:0]       w_gap;

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            r_pre <= '0;
        end else if (r_pre == PRE_LAST) begin
            r_pre <= '0;
        end else begin
            r_pre <= r_pre + 1'b1;
        end
    end

    assign w_tick = i_tick_en && (r_pre == PRE_LAST);

    // Step arithmetic is widened so speed + STEP never wraps past 255.
    assign w_up  = {2'b00, r_speed} + STEP_W;
    assign w_gap = r_speed - i_target;

    always_comb begin
        w_speed_d = r_speed;
        if (w_tick) begin
            if (r_speed < i_target) begin
                w_speed_d = (w_up >= {2'b00, i_target}) ? i_target : w_up[7:0];
            end else if (r_speed > i_target) begin
                w_speed_d = ({2'b00, w_gap} <= STEP_W) ? i_target : (r_speed - STEP_W[7:0]);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            r_speed <= 8'd0;
        end else begin
            r_speed <= w_speed_d;
        end
    end

    assign o_speed = r_speed;

endmodule

// File: rtl/temp_regulator.sv
// Fan-speed temperature regulator: hysteretic COOL/HEAT selection on the
// registered sample, slew-limited fan request and a missing-sample watchdog.
module temp_regulator
    import temp_reg_pkg::*;
#(
    parameter int unsigned GAIN     = GAIN_DEF,
    parameter int unsigned STEP     = STEP_DEF,
    parameter int unsigned RAMP_DIV = RAMP_DIV_DEF,
    parameter int unsigned TIMEOUT  = TIMEOUT_DEF
) (
    input  logic       i_clk,
    input  logic       i_arst_n,
    input  logic       i_temp_valid,
    input  logic [7:0] i_temp,
    input  logic [7:0] i_set_point,
    input  logic [3:0] i_hyst,
    output logic [7:0] o_speed,
    output logic       o_chs_mode,
    output logic       o_chs_en,
    output logic       o_fault
);

    localparam int unsigned     WD_W    = $clog2(TIMEOUT) + 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    logic [7:0]      r_sample;
    logic            r_seen;
    logic [1:0]      r_state;
    logic [1:0]      w_state_d;
    logic            r_chs_mode;
    logic [WD_W-1:0] r_wdog;
    logic [8:0]      w_hi;
    logic [8:0]      w_lo;
    logic [8:0]      w_smp9;
    logic [7:0]      w_target;
    logic [7:0]      w_speed;
    logic            w_timeout;

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            r_sample <= 8'd0;
            r_seen   <= 1'b0;
        end else if (i_temp_valid) begin
            r_sample <= i_temp;
            r_seen   <= 1'b1;
        end
    end

    // Counter parks at its last value so FAULT stays asserted until a sample.
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            r_wdog <= '0;
        end else if (i_temp_valid) begin
            r_wdog <= '0;
        end else if (r_seen && (r_wdog != WD_LAST)) begin
            r_wdog <= r_wdog + 1'b1;
        end
    end

    assign w_timeout = r_seen && !i_temp_valid && (r_wdog == WD_LAST);

    assign w_hi   = {1'b0, i_set_point} + {5'b00000, i_hyst};
    assign w_lo   = (i_set_point >= {4'b0000, i_hyst}) ?
                    {1'b0, i_set_point - {4'b0000, i_hyst}} : 9'd0;
    assign w_smp9 = {1'b0, r_sample};

    always_comb begin
        w_target = 8'd0;
        case (r_state)
            ST_COOL: begin
                if (r_sample > i_set_point) begin
                    w_target = sat_scale(r_sample - i_set_point, GAIN);
                end
            end
            ST_HEAT: begin
                if (r_sample < i_set_point) begin
                    w_target = sat_scale(i_set_point - r_sample, GAIN);
                end
            end
            default: w_target = 8'd0;
        endcase
    end

    // COOL and HEAT only ever leave through IDLE, so a reversal ramps via 0.
    always_comb begin
        w_state_d = r_state;
        if (w_timeout) begin
            w_state_d = ST_FAULT;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (r_seen && (w_smp9 > w_hi)) begin
                        w_state_d = ST_COOL;
                    end else if (r_seen && (w_smp9 < w_lo)) begin
                        w_state_d = ST_HEAT;
                    end
                end
                ST_COOL, ST_HEAT: begin
                    if ((w_target == 8'd0) && (w_speed == 8'd0)) begin
                        w_state_d = ST_IDLE;
                    end
                end
                ST_FAULT: begin
                    if (i_temp_valid && (w_speed == 8'd0)) begin
                        w_state_d = ST_IDLE;
                    end
                end
                default: w_state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            r_state    <= ST_IDLE;
            r_chs_mode <= 1'b0;
        end else begin
            r_state <= w_state_d;
            if (w_state_d == ST_COOL) begin
                r_chs_mode <= 1'b1;
            end else if (w_state_d == ST_HEAT) begin
                r_chs_mode <= 1'b0;
            end
        end
    end

    ramp_limiter #(
        .STEP     (STEP),
        .RAMP_DIV (RAMP_DIV)
    ) u_ramp (
        .i_clk     (i_clk),
        .i_arst_n  (i_arst_n),
        .i_tick_en (1'b1),
        .i_target  (w_target),
        .o_speed   (w_speed)
    );

    assign o_speed    = w_speed;
    assign o_chs_mode = r_chs_mode;
    assign o_chs_en   = (r_state == ST_COOL) || (r_state == ST_HEAT);
    assign o_fault    = (r_state == ST_FAULT);

endmodule

// File: tb/tb_temp_regulator.sv
// Self-checking bench for temp_regulator: a rule-level model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_temp_regulator;

    localparam int GAIN = 4;
    localparam int STEP = 8;
    localparam int DIV  = 16;
    localparam int TMO  = 1024;

    localparam int S_IDLE  = 0;
    localparam int S_COOL  = 1;
    localparam int S_HEAT  = 2;
    localparam int S_FAULT = 3;

    logic       clk    = 1'b0;
    logic       arst_n = 1'b0;
    logic       valid  = 1'b0;
    logic [7:0] temp   = 8'd0;
    logic [7:0] sp     = 8'd25;
    logic [3:0] hyst   = 4'd2;
    logic [7:0] speed;
    logic       mode;
    logic       en;
    logic       fault;

    temp_regulator dut (
        .i_clk        (clk),
        .i_arst_n     (arst_n),
        .i_temp_valid (valid),
        .i_temp       (temp),
        .i_set_point  (sp),
        .i_hyst       (hyst),
        .o_speed      (speed),
        .o_chs_mode   (mode),
        .o_chs_en     (en),
        .o_fault      (fault)
    );

    always #5 clk = ~clk;

    int n_assert   = 0;
    int n_fail     = 0;
    bit chk_on     = 1'b0;
    bit refresh_on = 1'b0;
    int refresh_cnt = 0;

    task automatic check(input string name, input int act, input int exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_speed, m_sample, m_quiet, m_cycles, m_state;
    bit m_seen, m_mode;
    int n_speed, n_state, n_tgt, m_hi, m_lo;
    bit n_timeout;

    function automatic int model_target(input int st, input int smp, input int setp);
        int v;
        v = 0;
        if (st == S_COOL && smp > setp) v = (smp - setp) * GAIN;
        else if (st == S_HEAT && smp < setp) v = (setp - smp) * GAIN;
        return (v > 255) ? 255 : v;
    endfunction

    function automatic int ramp_next(input int cur, input int tgt);
        if (cur < tgt) return (cur + STEP > tgt) ? tgt : cur + STEP;
        if (cur > tgt) return (cur - STEP < tgt) ? tgt : cur - STEP;
        return cur;
    endfunction

    assign m_hi = int'(sp) + int'(hyst);
    assign m_lo = (int'(sp) > int'(hyst)) ? int'(sp) - int'(hyst) : 0;

    always_comb begin
        n_tgt     = model_target(m_state, m_sample, int'(sp));
        n_timeout = m_seen && !valid && (m_quiet + 1 >= TMO);
        n_speed   = ((m_cycles % DIV) == DIV - 1) ? ramp_next(m_speed, n_tgt) : m_speed;
        n_state   = m_state;
        if (n_timeout) begin
            n_state = S_FAULT;
        end else if (m_state == S_IDLE) begin
            if (m_seen && m_sample > m_hi) n_state = S_COOL;
            else if (m_seen && m_sample < m_lo) n_state = S_HEAT;
        end else if (m_state == S_FAULT) begin
            if (valid && m_speed == 0) n_state = S_IDLE;
        end else if (n_tgt == 0 && m_speed == 0) begin
            n_state = S_IDLE;
        end
    end

    always @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            m_speed  <= 0;
            m_sample <= 0;
            m_quiet  <= 0;
            m_cycles <= 0;
            m_state  <= S_IDLE;
            m_seen   <= 1'b0;
            m_mode   <= 1'b0;
        end else begin
            m_speed  <= n_speed;
            m_state  <= n_state;
            m_cycles <= m_cycles + 1;
            if (valid) begin
                m_sample <= int'(temp);
                m_seen   <= 1'b1;
                m_quiet  <= 0;
            end else if (m_seen) begin
                m_quiet <= m_quiet + 1;
            end
            if (n_state == S_COOL) m_mode <= 1'b1;
            else if (n_state == S_HEAT) m_mode <= 1'b0;
        end
    end

    // ---------------- per-cycle compare ----------------
    bit prev_en   = 1'b0;
    bit prev_mode = 1'b0;

    always @(negedge clk) begin
        if (chk_on) begin
            check("speed", int'(speed), m_speed);
            check("fault", int'(fault), int'(m_state == S_FAULT));
            check("chs_en", int'(en), int'(m_state == S_COOL || m_state == S_HEAT));
            check("chs_mode", int'(mode), int'(m_mode));
            if (en && prev_en) check("no_direct_reversal", int'(mode), int'(prev_mode));
        end
        prev_en   <= en;
        prev_mode <= mode;
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(negedge clk);
        refresh_cnt++;
        valid = refresh_on && ((refresh_cnt % 200) == 0);
    endtask

    task automatic send(input int t);
        temp  = 8'(t);
        valid = 1'b1;
        step();
    endtask

    task automatic expect_seq(input string name, input int start, input int seq[$]);
        int prev;
        int waited;
        prev = start;
        foreach (seq[i]) begin
            waited = 0;
            while (int'(speed) == prev && waited < 40) begin
                step();
                waited++;
            end
            check(name, int'(speed), seq[i]);
            prev = seq[i];
        end
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "bench time limit");
    end

    initial begin
        int q[$];
        repeat (3) @(negedge clk);
        arst_n = 1'b1;
        chk_on = 1'b1;
        check("reset_speed", int'(speed), 0);
        check("reset_en", int'(en), 0);
        check("reset_fault", int'(fault), 0);
        check("reset_mode", int'(mode), 0);

        // Inside the hysteresis band (hi = 27, lo = 23): nothing moves.
        refresh_on = 1'b1;
        foreach (q[i]) q.delete(i);
        q = '{26, 24, 27, 23};
        foreach (q[i]) begin
            send(q[i]);
            repeat (40) step();
            check("band_speed", int'(speed), 0);
            check("band_en", int'(en), 0);
        end

        // COOL ramp to 40.
        send(35);
        expect_seq("cool_ramp", 0, '{8, 16, 24, 32, 40});
        check("cool_mode", int'(mode), 1);
        check("cool_en", int'(en), 1);
        repeat (40) step();
        check("cool_hold", int'(speed), 40);

        // Reversal through zero and IDLE into HEAT (target 60).
        send(10);
        expect_seq("reverse", 40, '{32, 24, 16, 8, 0, 8, 16, 24, 32, 40, 48, 56, 60});
        check("heat_mode", int'(mode), 0);
        check("heat_en", int'(en), 1);

        // Back to COOL with a saturated target of 255.
        send(100);
        q.delete();
        q = '{52, 44, 36, 28, 20, 12, 4, 0};
        for (int v = 8; v < 255; v += 8) q.push_back(v);
        q.push_back(255);
        expect_seq("sat_ramp", 60, q);
        check("sat_mode", int'(mode), 1);

        // Down to 40, then the watchdog.
        send(35);
        q.delete();
        for (int v = 247; v > 40; v -= 8) q.push_back(v);
        q.push_back(40);
        expect_seq("down_to_40", 255, q);
        refresh_on = 1'b0;
        send(35);
        repeat (1023) step();
        send(35);
        check("coincident_no_fault", int'(fault), 0);
        repeat (1023) step();
        check("fault_not_yet", int'(fault), 0);
        step();
        check("fault_raised", int'(fault), 1);
        check("fault_en_low", int'(en), 0);
        expect_seq("fault_rampdown", 40, '{32, 24, 16, 8, 0});
        repeat (5) step();
        check("fault_held", int'(fault), 1);
        send(35);
        check("fault_cleared", int'(fault), 0);
        step();
        check("recool_en", int'(en), 1);
        refresh_on = 1'b1;

        // Reset mid-ramp at 24.
        expect_seq("reramp", 0, '{8, 16, 24});
        refresh_on = 1'b0;
        #2 arst_n = 1'b0;
        #1;
        check("reset_async_speed", int'(speed), 0);
        check("reset_async_en", int'(en), 0);
        @(negedge clk);
        #2 arst_n = 1'b1;
        repeat (100) step();
        check("post_reset_speed", int'(speed), 0);
        check("post_reset_en", int'(en), 0);
        check("post_reset_fault", int'(fault), 0);
        refresh_on = 1'b1;
        send(35);
        expect_seq("post_reset_ramp", 0, '{8, 16});
        check("post_reset_mode", int'(mode), 1);

        repeat (3) step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/temp_regulator.md
TEMP_REGULATOR -- requirements
Module: temp_regulator

Interface
REQ-001 The module SHALL have parameter GAIN, default 4, fan speed units per degree of error.
REQ-002 The module SHALL have parameter STEP, default 8, maximum speed change per ramp tick.
REQ-003 The module SHALL have parameter RAMP_DIV, default 16, clocks per ramp tick.
REQ-004 The module SHALL have parameter TIMEOUT, default 1024, clocks without a sample before a fault is raised.
REQ-005 clk  in  1  single system clock; all state changes on its rising edge.
REQ-006 arst  in  1  asynchronous reset, active-low.
REQ-007 temp_valid  in  1  one-cycle strobe marking temp as a fresh sample.
REQ-008 temp  in  8  unsigned sensor temperature in degrees.
REQ-009 set_point  in  8  unsigned target temperature in degrees.
REQ-010 hyst  in  4  unsigned hysteresis band in degrees.
REQ-011 speed  out  8  fan duty request, wired directly to the FanSpeed PWM stage.
REQ-012 chs_mode  out  1  1 = cooling, 0 = heating; valid while chs_en = 1.
REQ-013 chs_en  out  1  high in COOL or HEAT.
REQ-014 fault  out  1  high in FAULT.

Function
REQ-015 The sample register SHALL capture temp on every clock edge where temp_valid = 1; no other edge changes it.
REQ-016 The FSM SHALL have states IDLE, COOL, HEAT and FAULT, and SHALL stay in IDLE until the first sample is captured.
REQ-017 Threshold arithmetic SHALL be done at 9 bits: hi = set_point + hyst, with no wrap; lo = set_point - hyst, clamped at 0.
REQ-018 IDLE transitions: to COOL when the sample > hi; to HEAT when the sample < lo; otherwise hold.
REQ-019 COOL target SHALL be min(255, (sample - set_point) * GAIN) while sample > set_point, else 0.
REQ-020 HEAT target SHALL be min(255, (set_point - sample) * GAIN) while sample < set_point, else 0.
REQ-021 The product SHALL be computed at 12 bits minimum and saturated to 255.
REQ-022 COOL or HEAT SHALL return to IDLE only when target = 0 and speed = 0.
REQ-023 A direct COOL<->HEAT transition SHALL never occur; reversal always ramps through 0 and passes through IDLE.
REQ-024 A free-running prescaler SHALL assert a ramp tick once every RAMP_DIV clocks.
REQ-025 Speed update on a tick: if speed < target, speed = min(speed + STEP, target); if speed > target, speed = max(speed - STEP, target); comparisons SHALL be done without 8-bit overflow.
REQ-026 Speed SHALL change only on a ramp tick.
REQ-027 In IDLE, target SHALL be 0.
REQ-028 The FSM decision SHALL use the registered sample, so a state change is visible 2 clocks after the temp_valid edge.
REQ-029 A watchdog counter SHALL start after the first sample and clear on every temp_valid; reaching TIMEOUT SHALL force FAULT from any state.
REQ-030 In FAULT, target SHALL be 0 and fault SHALL be 1.
REQ-031 FAULT SHALL exit to IDLE on a temp_valid edge, but only once speed = 0.
REQ-032 chs_mode SHALL hold its last value in IDLE and FAULT.
REQ-033 If temp_valid coincides with the timeout cycle, the sample SHALL win and no fault SHALL be raised.

Reset
REQ-034 On arst low, the block SHALL immediately set: speed = 0, chs_en = 0, chs_mode = 0, fault = 0, state = IDLE, prescaler = 0, watchdog = 0, sample-seen flag = 0.
REQ-035 Reset asserted mid-ramp SHALL drop speed to 0 at once, with no ramp-down.

Structure
REQ-036 Package temp_reg_pkg SHALL hold the state encoding and the parameter defaults.
REQ-037 The slew limiter (prescaler plus step/clamp logic) SHALL be one sub-module, ramp_limiter, with inputs target and a tick enable and output speed.

Verification
REQ-038 The bench SHALL cover each of the following scenarios; all use default parameters.
- set_point = 25, hyst = 2, temp = 35: COOL, chs_mode = 1, speed steps 8/16/24/32/40 on successive ticks, reaching 40 after 5 ticks (80 clocks).
- temp = 100, set_point = 25 in COOL: target saturates at 255; speed climbs in steps of 8 and ends at 255 exactly.
- temp = 26, set_point = 25, hyst = 2 from IDLE: no transition, speed stays 0. temp = 24: no transition either.
- In COOL at speed 40, then temp = 10: speed ramps 32..0, state goes to IDLE, then HEAT with chs_mode = 0, and speed ramps to 60; chs_en never shows a COOL->HEAT edge without an intervening low.
- No temp_valid for 1024 clocks while at speed 40: fault = 1 and speed ramps to 0. The next temp_valid clears the fault to IDLE.
- arst pulsed low mid-ramp at speed 24: speed = 0 in the same cycle, and nothing happens until a new sample arrives.
